fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 29 ++
 rtl/uart_baud_cnt.sv | 40 ++++
 rtl/fifo_uart_tx.sv | 133 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// fifo_uart_pkg : shared constants and state encoding for fifo_uart_tx
// Revision 1.0
// ----------------------------------------------------------------
package fifo_uart_pkg;

   localparam int DATA_W = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_START  = ST_START,
      S_DATA   = ST_DATA,
      S_PARITY = ST_PARITY,
      S_STOP   = ST_STOP
   } state_e;

   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ----------------------------------------------------------------
// uart_baud_cnt : counts 0..CLKS_PER_BIT-1, ticks on the last cycle of a bit
// Revision 1.0
// ----------------------------------------------------------------
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic bit_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // clr holds the counter at zero so a bit period starts exactly when clr drops
   assign bit_tick = !clr && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || bit_tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------
// fifo_uart_tx : pops bytes from a FWFT FIFO and serialises them as UART frames
// Revision 1.0
// ----------------------------------------------------------------
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              rd,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam logic STOP_LAST = (STOP_BITS == 2);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              stop_cnt_q, stop_cnt_d;
   logic              parity_q, parity_d;
   logic              tx_q, tx_d;
   logic              armed_q;
   logic              bit_tick;

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (state_q == S_IDLE),
      .bit_tick (bit_tick)
   );

   assign busy = (state_q != S_IDLE);
   assign tx   = tx_q;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      parity_d   = parity_q;
      rd         = 1'b0;
      frame_done = 1'b0;
      tx_d       = 1'b1;

      case (state_q)
         S_IDLE: begin
            // armed_q keeps rd low until the first clock edge after reset release
            if (armed_q && tx_en && !fifo_empty) begin
               rd         = 1'b1;
               shift_d    = fifo_data;
               parity_d   = even_parity(fifo_data);
               bit_cnt_d  = 3'd0;
               stop_cnt_d = 1'b0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (bit_tick) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_tick) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (bit_tick) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_tick) begin
               if (stop_cnt_q == STOP_LAST) begin
                  frame_done = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // tx is registered from the next state so the line changes cleanly on the edge
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = parity_q;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= 3'd0;
         stop_cnt_q <= 1'b0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         parity_q   <= parity_d;
         tx_q       <= tx_d;
         armed_q    <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_fifo_uart_tx : three parameterisations of fifo_uart_tx against a frame scoreboard
// Revision 1.0
// ----------------------------------------------------------------
module tb_fifo_uart_tx;

   function automatic int cpb(input int c);
      return (c == 2) ? 2 : 4;
   endfunction
   function automatic int par(input int c);
      return (c == 1) ? 1 : 0;
   endfunction
   function automatic int sbits(input int c);
      return (c == 2) ? 2 : 1;
   endfunction

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] tx_en_v;
   logic [2:0] fifo_empty_v;
   logic [7:0] fifo_data_a [3];
   wire  [2:0] rd_v;
   wire  [2:0] tx_v;
   wire  [2:0] busy_v;
   wire  [2:0] fd_v;

   for (genvar i = 0; i < 3; i++) begin : g_cfg
      fifo_uart_tx #(
         .CLKS_PER_BIT (cpb(i)),
         .PARITY_EN    (par(i)),
         .STOP_BITS    (sbits(i))
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .tx_en      (tx_en_v[i]),
         .fifo_empty (fifo_empty_v[i]),
         .fifo_data  (fifo_data_a[i]),
         .rd         (rd_v[i]),
         .tx         (tx_v[i]),
         .busy       (busy_v[i]),
         .frame_done (fd_v[i])
      );
   end

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
      $fatal(1);
   end

   typedef struct {
      int         cfg;
      logic [7:0] b;
      logic       p;
      int         len;
      bit         chk_gap;
      int         gmin;
      int         gmax;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] fq[$];
   int         act;
   int         n_pushed = 0;
   bit         timeout_flag = 0;
   bit         finish_req = 0;

   // ---------------- stimulus: FIFO model and directed vectors ----------------
   task automatic drive();
      for (int c = 0; c < 3; c++) begin
         if (c == act && fq.size() > 0) begin
            fifo_empty_v[c]   = 1'b0;
            fifo_data_a[c]    = fq[0];
         end else begin
            fifo_empty_v[c]   = 1'b1;
            fifo_data_a[c]    = 8'h5B ^ 8'(c);
         end
      end
   endtask

   task automatic cyc();
      logic rd_seen;
      @(negedge clk);
      rd_seen = rd_v[act];
      @(posedge clk);
      #1;
      if (rd_seen && fq.size() > 0) fq.delete(0);
      drive();
   endtask

   task automatic push(input logic [7:0] b, input bit chk, input logic p, input int len,
                       input bit cg, input int gmin, input int gmax);
      exp_t e;
      fq.push_back(b);
      n_pushed++;
      if (chk) begin
         e.cfg = act; e.b = b; e.p = p; e.len = len;
         e.chk_gap = cg; e.gmin = gmin; e.gmax = gmax;
         exp_q.push_back(e);
      end
      drive();
   endtask

   task automatic wait_idle(input int maxc);
      int k;
      for (k = 0; k < maxc; k++) begin
         cyc();
         if (fq.size() == 0 && busy_v == 3'b000 && exp_q.size() == 0) break;
      end
      if (k == maxc) timeout_flag = 1;
      cyc();
      cyc();
   endtask

   task automatic wait_busy(input int maxc);
      int k;
      for (k = 0; k < maxc; k++) begin
         cyc();
         if (busy_v[act]) break;
      end
      if (k == maxc) timeout_flag = 1;
   endtask

   initial begin
      rst_n   = 1'b0;
      tx_en_v = 3'b000;
      act     = 0;
      drive();
      repeat (3) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      tx_en_v = 3'b111;

      // 8N1, 4 clocks/bit, single byte
      act = 0;
      push(8'hA5, 1, 1'b0, 40, 0, 0, 0);
      wait_idle(200);

      // three queued bytes go out back-to-back with one idle cycle between frames
      push(8'h11, 1, 1'b0, 40, 0, 0, 0);
      push(8'h22, 1, 1'b0, 40, 1, 1, 1);
      push(8'h33, 1, 1'b0, 40, 1, 1, 1);
      wait_idle(400);

      // even parity: A5 -> 0, 01 -> 1
      act = 1;
      drive();
      push(8'hA5, 1, 1'b0, 44, 0, 0, 0);
      push(8'h01, 1, 1'b1, 44, 1, 1, 1);
      wait_idle(300);

      // tx_en dropped at frame cycle 10: frame completes, next pop waits for tx_en
      act = 0;
      drive();
      push(8'h3C, 1, 1'b0, 40, 0, 0, 0);
      wait_busy(20);
      repeat (9) cyc();
      tx_en_v[0] = 1'b0;
      push(8'h5A, 1, 1'b0, 40, 1, 20, 1000);
      repeat (60) cyc();
      tx_en_v[0] = 1'b1;
      wait_idle(200);

      // two stop bits, 2 clocks/bit
      act = 2;
      drive();
      push(8'hC3, 1, 1'b0, 22, 0, 0, 0);
      push(8'h80, 1, 1'b0, 22, 1, 1, 1);
      wait_idle(200);

      // async reset at frame cycle 15 discards 0x00; 0x88 follows after release
      act = 0;
      drive();
      push(8'h00, 0, 1'b0, 0, 0, 0, 0);
      push(8'h88, 1, 1'b0, 40, 0, 0, 0);
      wait_busy(20);
      repeat (14) cyc();
      #1;
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      wait_idle(200);

      finish_req = 1;
   end

   // ---------------- monitor / scoreboard ----------------
   int   vec = 0;
   int   mis = 0;
   int   cnt [3];
   int   gap [3];
   logic [2:0] busy_prev = 3'b000;
   logic [2:0] rd_prev   = 3'b000;
   logic cap [3][64];
   int   rd_total = 0;
   bit   in_rst = 0;
   exp_t e_m;

   function automatic logic exp_bit(input int c, input logic [7:0] b, input logic p, input int k);
      int idx;
      idx = k / cpb(c);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (par(c) != 0 && idx == 9) return p;
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         if (!in_rst) begin
            for (int c = 0; c < 3; c++) begin
               vec++;
               if ({tx_v[c], busy_v[c], rd_v[c], fd_v[c]} !== 4'b1000) begin
                  mis++;
                  $display("FAIL reset_out cfg%0d: tx/busy/rd/done=%b%b%b%b required 1000",
                           c, tx_v[c], busy_v[c], rd_v[c], fd_v[c]);
               end
            end
         end
         in_rst = 1;
         for (int c = 0; c < 3; c++) begin
            cnt[c] = 0;
            gap[c] = 1000;
         end
         busy_prev = 3'b000;
         rd_prev   = 3'b000;
      end else begin
         in_rst = 0;
         for (int c = 0; c < 3; c++) begin
            if (rd_v[c]) begin
               vec++;
               rd_total++;
               if (!(tx_en_v[c] && !fifo_empty_v[c] && !rd_prev[c] && !busy_v[c])) begin
                  mis++;
                  $display("FAIL rd_legal cfg%0d: rd=1 with tx_en=%b empty=%b prev_rd=%b busy=%b, required tx_en=1 empty=0 prev_rd=0 busy=0",
                           c, tx_en_v[c], fifo_empty_v[c], rd_prev[c], busy_v[c]);
               end
            end
            if (busy_v[c] && !busy_prev[c]) begin
               vec++;
               if (!rd_prev[c]) begin
                  mis++;
                  $display("FAIL start_after_rd cfg%0d: previous rd=%b required 1", c, rd_prev[c]);
               end
               if (exp_q.size() == 0) begin
                  vec++;
                  mis++;
                  $display("FAIL unexpected_frame cfg%0d: frame started, required none", c);
               end else if (exp_q[0].chk_gap) begin
                  vec++;
                  if (gap[c] < exp_q[0].gmin || gap[c] > exp_q[0].gmax) begin
                     mis++;
                     $display("FAIL idle_gap cfg%0d: gap %0d required %0d..%0d",
                              c, gap[c], exp_q[0].gmin, exp_q[0].gmax);
                  end
               end
               cnt[c] = 0;
            end
            if (busy_v[c]) begin
               if (cnt[c] < 64) cap[c][cnt[c]] = tx_v[c];
               cnt[c]++;
            end else if (gap[c] < 1000) begin
               gap[c]++;
            end
            if (fd_v[c]) begin
               if (exp_q.size() == 0) begin
                  vec++;
                  mis++;
                  $display("FAIL unexpected_done cfg%0d: frame_done with empty scoreboard", c);
               end else begin
                  int errs;
                  e_m = exp_q.pop_front();
                  vec++;
                  if (e_m.cfg != c) begin
                     mis++;
                     $display("FAIL frame_cfg: done on cfg%0d required cfg%0d (byte %h)", c, e_m.cfg, e_m.b);
                  end
                  vec++;
                  if (cnt[c] != e_m.len) begin
                     mis++;
                     $display("FAIL frame_len cfg%0d byte %h: %0d cycles required %0d", c, e_m.b, cnt[c], e_m.len);
                  end
                  errs = 0;
                  for (int k = 0; k < cnt[c] && k < 64; k++) begin
                     if (cap[c][k] !== exp_bit(c, e_m.b, e_m.p, k)) errs++;
                  end
                  vec++;
                  if (errs != 0) begin
                     mis++;
                     $display("FAIL frame_wave cfg%0d byte %h: %0d wrong tx cycles required 0", c, e_m.b, errs);
                  end
               end
               gap[c] = 0;
            end
            busy_prev[c] = busy_v[c];
            rd_prev[c]   = rd_v[c];
         end
      end

      if (finish_req) begin
         vec++;
         if (timeout_flag) begin
            mis++;
            $display("FAIL timeout: a wait expired, required none");
         end
         vec++;
         if (exp_q.size() != 0) begin
            mis++;
            $display("FAIL pending_frames: %0d left required 0", exp_q.size());
         end
         vec++;
         if (rd_total != n_pushed) begin
            mis++;
            $display("FAIL rd_count: %0d pulses required %0d", rd_total, n_pushed);
         end
         vec++;
         if (busy_v !== 3'b000 || rd_v !== 3'b000) begin
            mis++;
            $display("FAIL final_idle: busy=%b rd=%b required 000/000", busy_v, rd_v);
         end
         $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
         $finish;
      end
   end

endmodule
`default_nettype wire
